// File: rtl/t_counter_pkg.sv
// Shared definitions for the t_counter toggle/counter primitive.
// Holds the 2-bit mode encoding used on the t_counter mode port.
package t_counter_pkg;

  // Operating modes applied on each enabled, non-load clock edge
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_t;

endpackage

// File: rtl/t_counter_t_cell.sv
// Single T flip-flop: toggles its state on a rising clk edge when t is high.
// Asynchronous active-low reset forces q to RESET_BIT.
module t_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // Toggle storage; reset value is set per bit by the parent counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_counter.sv
// t_counter: WIDTH-bit bank of T cells acting as hold / toggle / up / down
// counter modulo MODULO, with synchronous load and a one-cycle wrap pulse.
// Optional macro T_COUNTER_SAT_EN: boundary steps saturate instead of wrap.
module t_counter
  import t_counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULO    = (64'd1 << WIDTH),
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

`ifdef T_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] UP_BOUND   = MAX_VAL;
  localparam logic [WIDTH-1:0] DOWN_BOUND = '0;
`else
  localparam logic [WIDTH-1:0] UP_BOUND   = '0;
  localparam logic [WIDTH-1:0] DOWN_BOUND = MAX_VAL;
`endif

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t_bits;
  logic             next_wrap;
  mode_t            cur_mode;

  assign cur_mode = mode_t'(mode);

  // Next-state selection: load beats enable, enable gates the mode action
  always_comb begin
    next_q    = q_bits;
    next_wrap = 1'b0;
    if (load) begin
      next_q = load_val;
    end else if (en) begin
      case (cur_mode)
        MODE_TOGGLE: next_q = q_bits ^ t_mask;
        MODE_UP: begin
          if (q_bits >= MAX_VAL) begin
            next_q    = UP_BOUND;
            next_wrap = 1'b1;
          end else begin
            next_q = q_bits + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q_bits == '0) begin
            next_q    = DOWN_BOUND;
            next_wrap = 1'b1;
          end else begin
            next_q = q_bits - 1'b1;
          end
        end
        default: next_q = q_bits;
      endcase
    end
  end

  assign t_bits = q_bits ^ next_q;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      t_cell #(.RESET_BIT(RST_VAL[i])) u_cell (
        .clk   (clk),
        .reset (reset),
        .t     (t_bits[i]),
        .q     (q_bits[i])
      );
    end
  endgenerate

  // Wrap pulse register, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= next_wrap;
    end
  end

  assign q  = q_bits;
  assign qn = ~q_bits;

endmodule

// File: tb/tb_t_counter.sv
// Self-checking bench for t_counter (WIDTH=4, MODULO=10, RESET_VAL=0).
// Builds with or without T_COUNTER_SAT_EN; the reference model follows it.
module tb_t_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] t_mask = '0;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         wrap;

  int checks = 0;
  int fails  = 0;
  int mq     = 0;
  int mw     = 0;

`ifdef T_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  t_counter #(.WIDTH(W), .MODULO(MOD), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .t_mask   (t_mask),
    .q        (q),
    .qn       (qn),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one clock edge does to the count, in plain integers
  task automatic predict(input bit ld, input int lv, input bit e, input int m, input int mask);
    if (ld) begin
      mq = lv; mw = 0;
    end else if (!e || m == 0) begin
      mw = 0;
    end else if (m == 1) begin
      mq = (mq ^ mask) % 16; mw = 0;
    end else if (m == 2) begin
      if (mq >= MOD - 1) begin mq = SAT ? MOD - 1 : 0; mw = 1; end
      else begin mq = mq + 1; mw = 0; end
    end else begin
      if (mq == 0) begin mq = SAT ? 0 : MOD - 1; mw = 1; end
      else begin mq = mq - 1; mw = 0; end
    end
  endtask

  // One clock edge: drive at negedge, compare model #1 after the rising edge
  task automatic applyStimulus(input bit ld, input int lv, input bit e, input int m, input int mask);
    load = ld; load_val = W'(lv); en = e; mode = 2'(m); t_mask = W'(mask);
    predict(ld, lv, e, m, mask);
    @(posedge clk);
    #1;
    checkOutput("model_q", int'(q), mq);
    checkOutput("model_qn", int'(qn), (~mq) & 15);
    checkOutput("model_wrap", int'(wrap), mw);
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two edges
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_q", int'(q), 0);
    checkOutput("rst_qn", int'(qn), 15);
    checkOutput("rst_wrap", int'(wrap), 0);
    @(negedge clk);
    reset = 1'b1; mq = 0; mw = 0;

    // Toggle with mask 0101
    applyStimulus(0, 0, 1, 1, 5); checkOutput("tog_1", int'(q), 5);
    applyStimulus(0, 0, 1, 1, 5); checkOutput("tog_2", int'(q), 0);
    applyStimulus(0, 0, 1, 1, 5); checkOutput("tog_3", int'(q), 5);

    // Count up through the boundary
    applyStimulus(1, 0, 1, 2, 0);
    for (int i = 1; i <= 9; i++) applyStimulus(0, 0, 1, 2, 0);
    checkOutput("up_9", int'(q), 9);
    checkOutput("up_9_wrap", int'(wrap), 0);
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("up_10", int'(q), SAT ? 9 : 0);
    checkOutput("up_10_wrap", int'(wrap), 1);
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("up_11", int'(q), SAT ? 9 : 1);
    checkOutput("up_11_wrap", int'(wrap), SAT ? 1 : 0);

    // Down from zero
    applyStimulus(1, 0, 1, 3, 0);
    applyStimulus(0, 0, 1, 3, 0);
    checkOutput("down_bnd", int'(q), SAT ? 0 : 9);
    checkOutput("down_bnd_wrap", int'(wrap), 1);

    // Load beats en=0, then en=0 holds
    applyStimulus(1, 3, 1, 0, 0);
    applyStimulus(1, 7, 0, 2, 0);
    checkOutput("prio_load", int'(q), 7);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 2, 0);
    checkOutput("prio_hold", int'(q), 7);

    // Out-of-range UP
    applyStimulus(1, 12, 1, 2, 0);
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("oor_up", int'(q), SAT ? 9 : 0);
    checkOutput("oor_up_wrap", int'(wrap), 1);

    // Async reset between edges while a wrap pulse is showing
    applyStimulus(1, 9, 1, 2, 0);
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("pre_arst_wrap", int'(wrap), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_q", int'(q), 0);
    checkOutput("arst_qn", int'(qn), 15);
    checkOutput("arst_wrap", int'(wrap), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; mq = 0; mw = 0;
    applyStimulus(0, 0, 1, 2, 0);
    checkOutput("arst_resume", int'(q), 1);

    // Randomised traffic, including out-of-range loads
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
